ray_normal_result_collector: RTL and testbench
==============================================

Name: ray_normal_result_collector

Overview:
- Receiving end of the fire-and-forget normal-result stream: accepts hit_normal_unnormalized/output_valid pulses from the unified normal pipeline, which has no backpressure.
- Pairs each result with a metadata tag captured when the request was issued.
- Buffers results in a FIFO and presents them downstream on a valid/ready handshake.
- Grants credits to the issuer so results are never dropped.

Parameters:
- PIPE_LAT, 3, fixed latency in cycles from issue_valid to the matching res_valid.
- DEPTH, 8, result FIFO depth; power of 2, minimum 4.
- TAG_W, 16, width of the per-request tag (pixel/ray id).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- issue_valid  in  1  request issued to the normal pipeline this cycle (same pulse as its new_data).
- issue_tag  in  TAG_W  tag for the request issued this cycle.
- issue_ready  out  1  credit available; issuer asserts issue_valid only when this is 1.
- res_valid  in  1  output_valid from the normal pipeline.
- res_normal  in  96  hit_normal_unnormalized; x=[95:64], y=[63:32], z=[31:0], signed.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts the head.
- out_normal  out  96  head normal.
- out_tag  out  TAG_W  head tag.
- out_degenerate  out  1  head normal is all-zero.
- in_flight  out  clog2(PIPE_LAT+1)  requests issued whose results are not yet returned.
- fifo_count  out  clog2(DEPTH+1)  entries stored.
- err  out  3  sticky: [0] overrun, [1] orphan result, [2] lost result.

Behaviour:
- Reset values: all outputs 0 (out_normal/out_tag 0), issue_ready 1 after the reset cycle. FIFO, tag delay line, counters and err are cleared.
- Reset mid-operation discards stored entries and in-flight tags. The upstream pipeline shares rst, so no stale results are expected.
- Tag delay line:
  - PIPE_LAT stages of {v, tag}, shifted every cycle.
  - Stage 0 loads {issue_valid, issue_tag}.
  - The head (stage PIPE_LAT-1) lines up with res_valid of the same request.
- in_flight:
  - Increments on issue_valid and decrements when head v=1 leaves.
  - Both in the same cycle leaves it unchanged.
- Pairing, per cycle:
  - res_valid=1, head v=1: push {res_normal, head tag, res_normal==0}.
  - res_valid=1, head v=0: err[1] set, result dropped.
  - res_valid=0, head v=1: err[2] set, tag dropped.
- Push and pop rules:
  - A push is accepted if fifo_count<DEPTH, or if a pop happens in the same cycle.
  - Otherwise err[0] is set and the entry is dropped.
  - Pop occurs when out_valid && out_ready.
  - Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- FIFO is first-word-fall-through from a register array.
  - A result pushed at edge t is visible on out_* immediately after edge t when the FIFO was empty.
  - Latency res_valid to out_valid is 1 cycle.
- out_valid = (fifo_count != 0). out_* hold stable while out_valid && !out_ready.
- Credit:
  - issue_ready = (in_flight + fifo_count) < DEPTH, combinational from registers.
  - A pop in the current cycle does not raise issue_ready until the next cycle.
  - issue_valid while issue_ready=0 sets err[0]; the request is still tracked in the delay line.
- err bits are sticky until rst and have no effect on the data path.
- out_degenerate is computed at push time and stored with the entry.

Test Plan:
- Single request: issue tag=0x0042 at cycle 0; res_valid with normal {1,2,3} at cycle 3.
  - Required: out_valid=1 at cycle 4 with out_tag=0x0042, out_normal={1,2,3}, out_degenerate=0; pops with out_ready=1; err=0.
- Credit fill: DEPTH=8, out_ready=0, issue every cycle while issue_ready with tags 0..7, results returned at +3.
  - Required: issue_ready drops after 8 issues; fifo_count reaches 8; no err.
  - Then out_ready=1: tags pop in order 0..7; issue_ready returns 1 the cycle after the first pop.
- Full with simultaneous push/pop: fifo_count=7, in_flight=1, out_ready=1 on the cycle the result arrives.
  - Required: push accepted, count stays at 7, err[0]=0, order preserved across pointer wrap.
- Orphan/lost: res_valid pulse with no prior issue.
  - Required: err[1]=1, fifo_count unchanged.
  - Then issue a request with res_valid held 0: err[2]=1 at cycle 3.
- Degenerate: result normal 96'h0 with tag 0x00FF.
  - Required: out_degenerate=1, out_tag=0x00FF.
- Reset mid-operation: 3 stored entries, 2 in flight, rst for 1 cycle.
  - Required: out_valid=0, fifo_count=0, in_flight=0, err=0, issue_ready=1 after reset; subsequent request behaves as in the single-request case.

Source files
------------

// File: rtl/ray_normal_result_collector_if.sv
// Bundle of the issue, result and output-side signals of the normal-result
// collector. The collector takes the slave view; the producer/consumer side
// (issuer, normal pipeline, downstream sink) takes the master view.
interface ray_normal_result_collector_if #(
  parameter int PIPE_LAT = 3,
  parameter int DEPTH    = 8,
  parameter int TAG_W    = 16
);
  localparam int IFL_W = $clog2(PIPE_LAT + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             issue_valid;
  logic [TAG_W-1:0] issue_tag;
  logic             issue_ready;
  logic             res_valid;
  logic [95:0]      res_normal;
  logic             out_valid;
  logic             out_ready;
  logic [95:0]      out_normal;
  logic [TAG_W-1:0] out_tag;
  logic             out_degenerate;
  logic [IFL_W-1:0] in_flight;
  logic [CNT_W-1:0] fifo_count;
  logic [2:0]       err;

  modport slave (
    input  issue_valid, issue_tag, res_valid, res_normal, out_ready,
    output issue_ready, out_valid, out_normal, out_tag, out_degenerate,
           in_flight, fifo_count, err
  );

  modport master (
    output issue_valid, issue_tag, res_valid, res_normal, out_ready,
    input  issue_ready, out_valid, out_normal, out_tag, out_degenerate,
           in_flight, fifo_count, err
  );
endinterface

// File: rtl/ray_normal_result_collector.sv
// Receiving end of the normal pipeline's fire-and-forget result stream.
// A tag delay line of PIPE_LAT stages re-associates each returning normal
// with the tag captured at issue time; paired results land in a
// first-word-fall-through FIFO drained by a valid/ready handshake. Credits
// (in-flight plus stored) gate the issuer so the FIFO can never overflow
// when the issuer obeys issue_ready. Protocol violations latch sticky err bits.
module ray_normal_result_collector #(
  parameter int PIPE_LAT = 3,
  parameter int DEPTH    = 8,
  parameter int TAG_W    = 16
) (
  input logic clk,
  input logic rst,
  ray_normal_result_collector_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IFL_W = $clog2(PIPE_LAT + 1);
  localparam int SUM_W = $clog2(PIPE_LAT + DEPTH + 1);

  typedef struct packed {
    logic [95:0]      normal;
    logic [TAG_W-1:0] tag;
    logic             degenerate;
  } entry_t;

  // Tag delay line: each stage is {valid, tag}
  logic [TAG_W:0] stage_in [PIPE_LAT];
  logic [TAG_W:0] dl_reg   [PIPE_LAT];

  // Result storage and bookkeeping
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [IFL_W-1:0] in_flight_reg, in_flight_next;
  logic [2:0]       err_reg, err_next;

  logic             head_v;
  logic [TAG_W-1:0] head_tag;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             out_valid;
  logic             issue_ready;
  logic             overrun;
  logic             orphan;
  logic             lost;
  logic [SUM_W-1:0] credit_used;
  entry_t           push_entry;
  entry_t           head_entry;

  // Stage 0 takes the request issued this cycle; later stages take their predecessor
  generate
    for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign stage_in[gi] = {bus.issue_valid, bus.issue_tag};
      end else begin : g_rest
        assign stage_in[gi] = dl_reg[gi-1];
      end
    end
  endgenerate

  // Shift the tag delay line every cycle; reset flushes in-flight tags
  always_ff @(posedge clk) begin
    for (int i = 0; i < PIPE_LAT; i++) begin
      if (rst) begin
        dl_reg[i] <= '0;
      end else begin
        dl_reg[i] <= stage_in[i];
      end
    end
  end

  assign head_v   = dl_reg[PIPE_LAT-1][TAG_W];
  assign head_tag = dl_reg[PIPE_LAT-1][TAG_W-1:0];

  // Credits count everything that will eventually occupy a FIFO slot
  assign credit_used = SUM_W'(in_flight_reg) + SUM_W'(count_reg);
  assign issue_ready = (credit_used < SUM_W'(DEPTH));
  assign out_valid   = (count_reg != '0);
  assign head_entry  = mem[rd_ptr_reg];

  // Pairing, push/pop acceptance, error detection and next-state values
  always_comb begin
    push_entry.normal     = bus.res_normal;
    push_entry.tag        = head_tag;
    push_entry.degenerate = (bus.res_normal == 96'd0);

    pop      = out_valid && bus.out_ready;
    push_req = bus.res_valid && head_v;
    // A full FIFO still accepts when the head leaves in the same cycle
    push_ok  = push_req && ((count_reg < CNT_W'(DEPTH)) || pop);

    overrun = (push_req && !push_ok) || (bus.issue_valid && !issue_ready);
    orphan  = bus.res_valid && !head_v;
    lost    = !bus.res_valid && head_v;

    wr_ptr_next    = push_ok ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    rd_ptr_next    = pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;
    count_next     = count_reg + CNT_W'(push_ok) - CNT_W'(pop);
    in_flight_next = in_flight_reg + IFL_W'(bus.issue_valid) - IFL_W'(head_v);
    err_next       = err_reg | {lost, orphan, overrun};
  end

  // Register the FIFO pointers, counters and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      in_flight_reg <= '0;
      err_reg       <= '0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      in_flight_reg <= in_flight_next;
      err_reg       <= err_next;
    end
  end

  // Write accepted results into the register array; contents need no reset
  // because the outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  assign bus.issue_ready    = issue_ready;
  assign bus.out_valid      = out_valid;
  assign bus.out_normal     = out_valid ? head_entry.normal : 96'd0;
  assign bus.out_tag        = out_valid ? head_entry.tag : '0;
  assign bus.out_degenerate = out_valid && head_entry.degenerate;
  assign bus.in_flight      = in_flight_reg;
  assign bus.fifo_count     = count_reg;
  assign bus.err            = err_reg;
endmodule

// File: tb/tb_ray_normal_result_collector.sv
// Directed bench for ray_normal_result_collector: a cycle table covers the
// single-request and degenerate-normal cases; hand sequences cover credit
// fill, full FIFO with simultaneous push/pop, orphan/lost results, overrun
// and reset in the middle of traffic.
module tb_ray_normal_result_collector;
  localparam int PIPE_LAT = 3;
  localparam int DEPTH    = 8;
  localparam int TAG_W    = 16;
  localparam logic [95:0] N123 = {32'd1, 32'd2, 32'd3};

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ray_normal_result_collector_if #(.PIPE_LAT(PIPE_LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  ray_normal_result_collector #(.PIPE_LAT(PIPE_LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus: inputs as driven, expected state just after the edge
  typedef struct packed {
    logic        iv;
    logic [15:0] itag;
    logic        rv;
    logic [95:0] rn;
    logic        ordy;
    logic        e_ov;
    logic [15:0] e_tag;
    logic [95:0] e_norm;
    logic        e_deg;
    logic [3:0]  e_fc;
    logic [1:0]  e_if;
    logic        e_ir;
    logic [2:0]  e_err;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [95:0] nrm(input int k);
    return {32'(k), 32'(k + 100), 32'(k + 200)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_tag   = '0;
    bus.res_valid   = 1'b0;
    bus.res_normal  = '0;
  endtask

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic check_state(input string nm, input logic e_ov, input logic [15:0] e_tag,
                             input logic [95:0] e_norm, input logic e_deg, input logic [3:0] e_fc,
                             input logic [1:0] e_if, input logic e_ir, input logic [2:0] e_err);
    check({nm, ".out_valid"}, bus.out_valid, e_ov);
    check({nm, ".out_tag"}, bus.out_tag, e_tag);
    check({nm, ".out_normal"}, bus.out_normal, e_norm);
    check({nm, ".out_degenerate"}, bus.out_degenerate, e_deg);
    check({nm, ".fifo_count"}, bus.fifo_count, e_fc);
    check({nm, ".in_flight"}, bus.in_flight, e_if);
    check({nm, ".issue_ready"}, bus.issue_ready, e_ir);
    check({nm, ".err"}, bus.err, e_err);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.issue_valid = vecs[i].iv;
      bus.issue_tag   = vecs[i].itag;
      bus.res_valid   = vecs[i].rv;
      bus.res_normal  = vecs[i].rn;
      bus.out_ready   = vecs[i].ordy;
      step();
      $display("vec %0d: out_valid=%0b out_tag=%h fifo_count=%0d", i, bus.out_valid, bus.out_tag, bus.fifo_count);
      check_state($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_tag, vecs[i].e_norm, vecs[i].e_deg,
                  vecs[i].e_fc, vecs[i].e_if, vecs[i].e_ir, vecs[i].e_err);
    end
    idle();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //            iv    itag      rv    rn      ordy  e_ov  e_tag     e_norm  deg   fc    if    ir    err
    vecs[0] = '{1'b1, 16'h0042, 1'b0, 96'h0, 1'b0, 1'b0, 16'h0000, 96'h0, 1'b0, 4'd0, 2'd1, 1'b1, 3'b000};
    vecs[1] = '{1'b0, 16'h0000, 1'b0, 96'h0, 1'b0, 1'b0, 16'h0000, 96'h0, 1'b0, 4'd0, 2'd1, 1'b1, 3'b000};
    vecs[2] = '{1'b0, 16'h0000, 1'b0, 96'h0, 1'b0, 1'b0, 16'h0000, 96'h0, 1'b0, 4'd0, 2'd1, 1'b1, 3'b000};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, N123,  1'b0, 1'b1, 16'h0042, N123,  1'b0, 4'd1, 2'd0, 1'b1, 3'b000};
    vecs[4] = '{1'b0, 16'h0000, 1'b0, 96'h0, 1'b1, 1'b0, 16'h0000, 96'h0, 1'b0, 4'd0, 2'd0, 1'b1, 3'b000};
    vecs[5] = '{1'b1, 16'h00FF, 1'b0, 96'h0, 1'b0, 1'b0, 16'h0000, 96'h0, 1'b0, 4'd0, 2'd1, 1'b1, 3'b000};
    vecs[6] = '{1'b0, 16'h0000, 1'b0, 96'h0, 1'b0, 1'b0, 16'h0000, 96'h0, 1'b0, 4'd0, 2'd1, 1'b1, 3'b000};
    vecs[7] = '{1'b0, 16'h0000, 1'b0, 96'h0, 1'b0, 1'b0, 16'h0000, 96'h0, 1'b0, 4'd0, 2'd1, 1'b1, 3'b000};
    vecs[8] = '{1'b0, 16'h0000, 1'b1, 96'h0, 1'b0, 1'b1, 16'h00FF, 96'h0, 1'b1, 4'd1, 2'd0, 1'b1, 3'b000};
    vecs[9] = '{1'b0, 16'h0000, 1'b0, 96'h0, 1'b1, 1'b0, 16'h0000, 96'h0, 1'b0, 4'd0, 2'd0, 1'b1, 3'b000};

    idle();
    bus.out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    check_state("reset", 1'b0, 16'h0, 96'h0, 1'b0, 4'd0, 2'd0, 1'b1, 3'b000);
    rst = 1'b0;

    // Single request, then degenerate normal
    run_vecs(0, 9);

    // Credit fill: tags 0..7 issued back to back, nothing drained
    for (int c = 0; c < 11; c++) begin
      check($sformatf("fill.issue_ready%0d", c), bus.issue_ready, c < 8);
      bus.issue_valid = (c < 8);
      bus.issue_tag   = 16'(c);
      bus.res_valid   = (c >= 3);
      bus.res_normal  = nrm(c - 3);
      step();
    end
    idle();
    check("fill.fifo_count", bus.fifo_count, 4'd8);
    check("fill.in_flight", bus.in_flight, 2'd0);
    check("fill.err", bus.err, 3'b000);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      $display("fill pop %0d: tag=%h", k, bus.out_tag);
      check($sformatf("fill.pop%0d.valid", k), bus.out_valid, 1'b1);
      check($sformatf("fill.pop%0d.tag", k), bus.out_tag, 16'(k));
      check($sformatf("fill.pop%0d.normal", k), bus.out_normal, nrm(k));
      check($sformatf("fill.pop%0d.issue_ready", k), bus.issue_ready, k != 0);
      step();
    end
    check("fill.empty", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;

    // Full-ish FIFO with push and pop in the same cycle, across pointer wrap
    for (int c = 0; c < 11; c++) begin
      bus.issue_valid = (c < 8);
      bus.issue_tag   = 16'(16 + c);
      bus.res_valid   = (c >= 3);
      bus.res_normal  = nrm(16 + c - 3);
      bus.out_ready   = (c == 10);
      if (c == 10) begin
        check("pp.pre_fifo_count", bus.fifo_count, 4'd7);
        check("pp.pre_in_flight", bus.in_flight, 2'd1);
      end
      step();
    end
    idle();
    check("pp.fifo_count", bus.fifo_count, 4'd7);
    check("pp.err", bus.err, 3'b000);
    bus.out_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      $display("pp pop %0d: tag=%h", k, bus.out_tag);
      check($sformatf("pp.pop%0d.tag", k), bus.out_tag, 16'(16 + k));
      check($sformatf("pp.pop%0d.normal", k), bus.out_normal, nrm(16 + k));
      step();
    end
    check("pp.empty", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;

    // Orphan result, then a lost result
    bus.res_valid  = 1'b1;
    bus.res_normal = nrm(5);
    step();
    idle();
    check("orphan.err", bus.err, 3'b010);
    check("orphan.fifo_count", bus.fifo_count, 4'd0);
    bus.issue_valid = 1'b1;
    bus.issue_tag   = 16'h0033;
    step();
    idle();
    step();
    step();
    check("lost.err_early", bus.err, 3'b010);
    step();
    check("lost.err", bus.err, 3'b110);
    check("lost.in_flight", bus.in_flight, 2'd0);
    check("lost.fifo_count", bus.fifo_count, 4'd0);

    // Overrun: ninth issue ignores issue_ready; its result finds the FIFO full
    for (int c = 0; c < 12; c++) begin
      if (c == 8) check("ovr.issue_ready", bus.issue_ready, 1'b0);
      bus.issue_valid = (c < 9);
      bus.issue_tag   = 16'(32 + c);
      bus.res_valid   = (c >= 3);
      bus.res_normal  = nrm(32 + c - 3);
      step();
      if (c == 8) check("ovr.err_issue", bus.err, 3'b111);
    end
    idle();
    check("ovr.fifo_count", bus.fifo_count, 4'd8);
    check("ovr.in_flight", bus.in_flight, 2'd0);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ovr.pop%0d.tag", k), bus.out_tag, 16'(32 + k));
      step();
    end
    check("ovr.dropped", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;

    // Reset with 3 entries stored and 2 requests in flight
    for (int c = 0; c < 6; c++) begin
      bus.issue_valid = (c < 5);
      bus.issue_tag   = 16'(64 + c);
      bus.res_valid   = (c >= 3);
      bus.res_normal  = nrm(64 + c - 3);
      step();
    end
    idle();
    check("mid.fifo_count", bus.fifo_count, 4'd3);
    check("mid.in_flight", bus.in_flight, 2'd2);
    check("mid.head_tag", bus.out_tag, 16'h0040);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_state("mid_reset", 1'b0, 16'h0, 96'h0, 1'b0, 4'd0, 2'd0, 1'b1, 3'b000);
    run_vecs(0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
